// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive strobed cycles without a response and
// flags expiry once the count reaches TIMEOUT_CYCLES (0 disables it).
module wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_done,
  output logic o_expire
);

  localparam int unsigned     CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count;

  // Fire only while the request is still strobed; the count cannot reach the
  // limit otherwise, but this keeps a dropped strobe from ever erroring.
  assign o_expire = ENABLED && i_active && (count == LIMIT);

  // Count stalled strobe cycles; any idle cycle, response or expiry restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (!i_active || i_done || o_expire) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone classic arbiter: round-robin grant held for
// the whole cyc tenure, responses routed only to the owner, stall watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_WIDTH-1:0] o_s_data,
  input  logic                  i_s_ack,
  input  logic                  i_s_err,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  arb_state_t state;
  logic       last_grant;
  logic [1:0] grant_q;

  logic                  sel_m0, sel_m1;
  logic                  req_cyc, req_stb, req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  expire;

  assign sel_m0 = (state == ARB_M0);
  assign sel_m1 = (state == ARB_M1);

  // Grant FSM: idle turnaround between every tenure, ties go to the master
  // that did not own the bus last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
      grant_q    <= GRANT_NONE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_m0_cyc && (!i_m1_cyc || last_grant)) begin
            state   <= ARB_M0;
            grant_q <= GRANT_M0;
          end else if (i_m1_cyc) begin
            state   <= ARB_M1;
            grant_q <= GRANT_M1;
          end
        end
        ARB_M0: begin
          if (!i_m0_cyc) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b0;
            grant_q    <= GRANT_NONE;
          end
        end
        ARB_M1: begin
          if (!i_m1_cyc) begin
            state      <= ARB_IDLE;
            last_grant <= 1'b1;
            grant_q    <= GRANT_NONE;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  assign o_grant = grant_q;

  // Request mux from the owning master; everything low when idle.
  always_comb begin
    req_cyc  = 1'b0;
    req_stb  = 1'b0;
    req_we   = 1'b0;
    req_addr = '0;
    req_data = '0;
    if (sel_m0) begin
      req_cyc  = i_m0_cyc;
      req_stb  = i_m0_stb;
      req_we   = i_m0_we;
      req_addr = i_m0_addr;
      req_data = i_m0_data;
    end else if (sel_m1) begin
      req_cyc  = i_m1_cyc;
      req_stb  = i_m1_stb;
      req_we   = i_m1_we;
      req_addr = i_m1_addr;
      req_data = i_m1_data;
    end
  end

  // Watchdog sees the unmasked strobe so its own expiry cannot feed back.
  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_active(req_stb),
    .i_done  (i_s_ack | i_s_err),
    .o_expire(expire)
  );

  assign o_s_cyc   = req_cyc;
  assign o_s_stb   = req_stb & ~expire;
  assign o_s_we    = req_we;
  assign o_s_addr  = req_addr;
  assign o_s_data  = req_data;
  assign o_timeout = expire;

  assign o_m0_ack  = sel_m0 & i_s_ack;
  assign o_m0_err  = sel_m0 & (i_s_err | expire);
  assign o_m0_data = sel_m0 ? i_s_data : '0;
  assign o_m1_ack  = sel_m1 & i_s_ack;
  assign o_m1_err  = sel_m1 & (i_s_err | expire);
  assign o_m1_data = sel_m1 ? i_s_data : '0;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with hand-computed expectations.
module tb_wb_arbiter2;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_m0_cyc, i_m0_stb, i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_data;
  logic          o_m0_ack, o_m0_err;
  logic [DW-1:0] o_m0_data;
  logic          i_m1_cyc, i_m1_stb, i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_data;
  logic          o_m1_ack, o_m1_err;
  logic [DW-1:0] o_m1_data;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [AW-1:0] o_s_addr;
  logic [DW-1:0] o_s_data;
  logic          i_s_ack, i_s_err;
  logic [DW-1:0] i_s_data;
  logic [1:0]    o_grant;
  logic          o_timeout;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wb_arbiter2 #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_m0_cyc (i_m0_cyc),
    .i_m0_stb (i_m0_stb),
    .i_m0_we  (i_m0_we),
    .i_m0_addr(i_m0_addr),
    .i_m0_data(i_m0_data),
    .o_m0_ack (o_m0_ack),
    .o_m0_err (o_m0_err),
    .o_m0_data(o_m0_data),
    .i_m1_cyc (i_m1_cyc),
    .i_m1_stb (i_m1_stb),
    .i_m1_we  (i_m1_we),
    .i_m1_addr(i_m1_addr),
    .i_m1_data(i_m1_data),
    .o_m1_ack (o_m1_ack),
    .o_m1_err (o_m1_err),
    .o_m1_data(o_m1_data),
    .o_s_cyc  (o_s_cyc),
    .o_s_stb  (o_s_stb),
    .o_s_we   (o_s_we),
    .o_s_addr (o_s_addr),
    .o_s_data (o_s_data),
    .i_s_ack  (i_s_ack),
    .i_s_err  (i_s_err),
    .i_s_data (i_s_data),
    .o_grant  (o_grant),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // a few ns later, well away from the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_m0_cyc = on; i_m0_stb = on; i_m0_we = we; i_m0_addr = a; i_m0_data = d;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_m1_cyc = on; i_m1_stb = on; i_m1_we = we; i_m1_addr = a; i_m1_data = d;
  endtask

  initial begin
    i_rst = 1'b1;
    m0_req(1'b0, 1'b0, '0, '0);
    m1_req(1'b0, 1'b0, '0, '0);
    i_s_ack = 1'b0; i_s_err = 1'b0; i_s_data = '0;

    // Reset state
    #2;
    chk("rst_grant", {30'd0, o_grant}, 32'd0);
    chk("rst_s_cyc", {31'd0, o_s_cyc}, 32'd0);
    chk("rst_s_stb", {31'd0, o_s_stb}, 32'd0);
    tick(); tick();
    #2;
    i_rst = 1'b0;
    tick(); settle();
    chk("post_rst_grant", {30'd0, o_grant}, 32'd0);
    chk("post_rst_timeout", {31'd0, o_timeout}, 32'd0);

    // Tie from reset: m0 first, m1 two cycles after m0 drops
    m0_req(1'b1, 1'b0, 4'h1, '0);
    m1_req(1'b1, 1'b0, 4'h2, '0);
    tick(); settle();
    chk("tie_grant_m0", {30'd0, o_grant}, 32'h1);
    chk("tie_addr_m0", {28'd0, o_s_addr}, 32'h1);
    m0_req(1'b0, 1'b0, '0, '0);
    tick(); settle();
    chk("turnaround_grant", {30'd0, o_grant}, 32'h0);
    chk("turnaround_stb", {31'd0, o_s_stb}, 32'h0);
    tick(); settle();
    chk("tie_grant_m1", {30'd0, o_grant}, 32'h2);
    chk("tie_addr_m1", {28'd0, o_s_addr}, 32'h2);
    i_s_ack = 1'b1; i_s_data = 32'h55;
    settle();
    chk("tie_m1_ack", {31'd0, o_m1_ack}, 32'h1);
    chk("tie_m0_ack", {31'd0, o_m0_ack}, 32'h0);
    chk("tie_m1_data", o_m1_data, 32'h55);
    m1_req(1'b0, 1'b0, '0, '0);
    tick();
    i_s_ack = 1'b0; i_s_data = '0;
    settle();
    chk("m1_release_grant", {30'd0, o_grant}, 32'h0);
    m0_req(1'b1, 1'b0, 4'h3, '0);
    m1_req(1'b1, 1'b0, 4'h4, '0);
    tick(); settle();
    chk("alt_tie_grant_m0", {30'd0, o_grant}, 32'h1);
    m0_req(1'b0, 1'b0, '0, '0);
    m1_req(1'b0, 1'b0, '0, '0);
    tick(); settle();
    chk("alt_release_grant", {30'd0, o_grant}, 32'h0);

    // Single master write of 0x41 to addr 0x8
    m0_req(1'b1, 1'b1, 4'h8, 32'h41);
    tick(); settle();
    chk("wr_s_stb", {31'd0, o_s_stb}, 32'h1);
    chk("wr_s_we", {31'd0, o_s_we}, 32'h1);
    chk("wr_s_addr", {28'd0, o_s_addr}, 32'h8);
    chk("wr_s_data", o_s_data, 32'h41);
    chk("wr_grant", {30'd0, o_grant}, 32'h1);
    chk("wr_m0_ack_early", {31'd0, o_m0_ack}, 32'h0);
    tick();
    i_s_ack = 1'b1;
    settle();
    chk("wr_m0_ack", {31'd0, o_m0_ack}, 32'h1);
    chk("wr_m1_ack", {31'd0, o_m1_ack}, 32'h0);
    chk("wr_m0_err", {31'd0, o_m0_err}, 32'h0);
    m0_req(1'b0, 1'b0, '0, '0);
    tick();
    i_s_ack = 1'b0;
    settle();
    chk("wr_release_grant", {30'd0, o_grant}, 32'h0);

    // Long m1 tenure, m0 pending throughout (last owner m0, so m1 wins tie)
    m0_req(1'b1, 1'b1, 4'h5, 32'h99);
    m1_req(1'b1, 1'b0, 4'h0, '0);
    tick(); settle();
    for (int k = 0; k < 3; k++) begin
      i_s_ack = 1'b1; i_s_data = 32'hA0 + k;
      settle();
      chk("long_grant", {30'd0, o_grant}, 32'h2);
      chk("long_m1_ack", {31'd0, o_m1_ack}, 32'h1);
      chk("long_m1_data", o_m1_data, 32'hA0 + k);
      chk("long_m0_ack", {31'd0, o_m0_ack}, 32'h0);
      chk("long_m0_data", o_m0_data, 32'h0);
      if (k == 2) m1_req(1'b0, 1'b0, '0, '0);
      tick();
    end
    i_s_ack = 1'b0; i_s_data = '0;
    settle();
    chk("long_turnaround", {30'd0, o_grant}, 32'h0);
    tick(); settle();
    chk("long_m0_after", {30'd0, o_grant}, 32'h1);
    m0_req(1'b0, 1'b0, '0, '0);
    tick(); settle();

    // Watchdog, TIMEOUT_CYCLES = 4, slave never answers
    m0_req(1'b1, 1'b0, 4'h6, '0);
    tick(); settle();
    chk("wd_stb_rise", {31'd0, o_s_stb}, 32'h1);
    for (int c = 2; c <= 4; c++) begin
      tick(); settle();
      chk("wd_no_err", {31'd0, o_m0_err}, 32'h0);
      chk("wd_no_timeout", {31'd0, o_timeout}, 32'h0);
      chk("wd_stb_held", {31'd0, o_s_stb}, 32'h1);
    end
    tick(); settle();
    chk("wd_err", {31'd0, o_m0_err}, 32'h1);
    chk("wd_timeout", {31'd0, o_timeout}, 32'h1);
    chk("wd_stb_masked", {31'd0, o_s_stb}, 32'h0);
    chk("wd_m1_err", {31'd0, o_m1_err}, 32'h0);
    m0_req(1'b0, 1'b0, '0, '0);
    tick(); settle();
    chk("wd_pulse_end", {31'd0, o_timeout}, 32'h0);
    chk("wd_err_end", {31'd0, o_m0_err}, 32'h0);

    // Abort: m0 drops after one strobe cycle, late ack is lost
    m0_req(1'b1, 1'b0, 4'h7, '0);
    tick(); settle();
    chk("abort_stb", {31'd0, o_s_stb}, 32'h1);
    m0_req(1'b0, 1'b0, '0, '0);
    tick();
    i_s_ack = 1'b1;
    settle();
    chk("abort_m0_ack", {31'd0, o_m0_ack}, 32'h0);
    chk("abort_m1_ack", {31'd0, o_m1_ack}, 32'h0);
    chk("abort_idle", {30'd0, o_grant}, 32'h0);
    tick();
    i_s_ack = 1'b0;
    settle();

    // Async reset during m1 read; afterwards m0 wins the tie again
    m1_req(1'b1, 1'b0, 4'h0, '0);
    tick(); settle();
    i_s_ack = 1'b1; i_s_data = 32'hBEEF;
    settle();
    chk("ar_m1_ack_before", {31'd0, o_m1_ack}, 32'h1);
    i_rst = 1'b1;
    settle();
    chk("ar_grant", {30'd0, o_grant}, 32'h0);
    chk("ar_s_cyc", {31'd0, o_s_cyc}, 32'h0);
    chk("ar_s_stb", {31'd0, o_s_stb}, 32'h0);
    chk("ar_m1_ack", {31'd0, o_m1_ack}, 32'h0);
    chk("ar_m1_data", o_m1_data, 32'h0);
    i_s_ack = 1'b0; i_s_data = '0;
    m1_req(1'b0, 1'b0, '0, '0);
    tick(); settle();
    i_rst = 1'b0;
    m0_req(1'b1, 1'b0, 4'h1, '0);
    m1_req(1'b1, 1'b0, 4'h2, '0);
    tick(); settle();
    chk("ar_tie_m0", {30'd0, o_grant}, 32'h1);
    m0_req(1'b0, 1'b0, '0, '0);
    m1_req(1'b0, 1'b0, '0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
